// File: rtl/mem_bus_responder_if.sv
// CPU memory-bus signal bundle: the CPU drives the request side (master) and
// the responder returns data plus the completion handshake (slave).
interface mem_bus_if;
  logic        Req;
  logic        Wr;
  logic [31:0] Address;
  logic [31:0] Datain;
  logic [31:0] Dataout;
  logic        Ready;
  logic        AddrError;
  logic        Busy;

  modport master (
    output Req, Wr, Address, Datain,
    input  Dataout, Ready, AddrError, Busy
  );

  modport slave (
    input  Req, Wr, Address, Datain,
    output Dataout, Ready, AddrError, Busy
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-organised memory responder with LATENCY wait states, a constant exception-vector
// word at byte 252 and address-error flagging. Optional AccessCount port: MEM_BUS_RESPONDER_ACCESS_COUNT_EN.
module mem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [7:0]  VEC_OPCODE  = 8'd254,
  parameter logic [7:0]  VEC_OVF     = 8'd255
) (
  input  logic            Clk,
  input  logic            Reset,
  mem_bus_if.slave        bus
`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
  ,
  output logic [15:0]     AccessCount
`endif
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] VEC_ADDR = 32'd252;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               wr_q,    wr_d;
  logic [31:0]        addr_q,  addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_q,  dout_d;
  logic               err_q,   err_d;

  logic               enter_resp;
  logic               misaligned;
  logic               is_vec;
  logic               out_of_range;
  logic               addr_err;
  logic               mem_we;
  logic [IDX_W-1:0]   widx;

  logic [31:0]        mem_q [DEPTH_WORDS];

  // Next-state logic; the *_d capture values double as the "current access"
  // so LATENCY=1 (capture and commit on the same edge) needs no special path.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Req) begin
          wr_d    = bus.Wr;
          addr_d  = bus.Address;
          wdata_d = bus.Datain;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The vector word wins over the range check; 252 is word-aligned, so it never overlaps misalignment.
  assign misaligned   = (addr_d[1:0] != 2'b00);
  assign is_vec       = (addr_d == VEC_ADDR);
  assign out_of_range = ({2'b00, addr_d[31:2]} >= 32'(DEPTH_WORDS));
  assign addr_err     = misaligned | (!is_vec & out_of_range);
  assign widx         = addr_d[IDX_W+1:2];
  assign mem_we       = enter_resp & wr_d & !addr_err & !is_vec & !Reset;

  always_comb begin
    dout_d = dout_q;
    err_d  = err_q;
    if (enter_resp) begin
      err_d = addr_err;
      if (!wr_d && !misaligned) begin
        if (is_vec)            dout_d = {16'h0000, VEC_OPCODE, VEC_OVF};
        else if (out_of_range) dout_d = 32'h0;
        else                   dout_d = mem_q[widx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the store is deliberately left out of reset so it maps onto plain RAM and survives Reset.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[widx] <= wdata_d;
  end

  assign bus.Ready     = (state_q == ST_RESP);
  assign bus.AddrError = (state_q == ST_RESP) & err_q;
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.Dataout   = dout_q;

`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
  logic [15:0] acc_cnt_q;

  // Counts completed responses of every kind; wraps naturally at 16 bits.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                   acc_cnt_q <= '0;
    else if (state_q == ST_RESP) acc_cnt_q <= acc_cnt_q + 16'd1;
  end

  assign AccessCount = acc_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: a word-array reference model predicts each
// response at issue time; a monitor pops and compares whenever Ready is due or seen.
module tb_mem_bus_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] dout;
    logic        err;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_if bus_a ();
  mem_bus_if bus_b ();

`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_a)
`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
    , .AccessCount(cnt_a)
`endif
  );

  mem_bus_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_b)
`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
    , .AccessCount(cnt_b)
`endif
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          next_free   = 0;
  sb_entry_t   sb[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] dout_m = 32'h0;
  logic [15:0] acc_m  = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one access, straight from the address-map rules.
  function automatic void model_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] dout, output logic err);
    if (a[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (a == 32'd252) begin
      err = 1'b0;
      if (!wr) dout_m = 32'h0000FEFF;
    end else if ((a >> 2) >= 32'(DEPTH)) begin
      err = 1'b1;
      if (!wr) dout_m = 32'h0;
    end else begin
      err = 1'b0;
      if (wr) mem_m[int'(a >> 2)] = d;
      else    dout_m = mem_m[int'(a >> 2)];
    end
    dout = dout_m;
  endfunction

  task automatic randomize_bus_a();
    bus_a.Req     = 1'($urandom_range(0, 1));
    bus_a.Wr      = 1'($urandom_range(0, 1));
    bus_a.Address = $urandom;
    bus_a.Datain  = $urandom;
  endtask

  // Returns at the negedge just before the first edge where the responder is idle;
  // while busy, the bus carries noise that must be ignored.
  task automatic wait_idle();
    @(negedge clk);
    while (cyc + 1 < next_free) begin
      randomize_bus_a();
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    sb_entry_t e;
    wait_idle();
    bus_a.Req     = 1'b1;
    bus_a.Wr      = wr;
    bus_a.Address = a;
    bus_a.Datain  = d;
    model_access(wr, a, d, e.dout, e.err);
    e.wr  = wr;
    e.due = cyc + LAT;
    sb.push_back(e);
    next_free = cyc + LAT + 2;
    @(negedge clk);
    bus_a.Req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_a.Req = 1'b0;
    end
  endtask

  task automatic drain();
    bus_a.Req = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'd252;
      1:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      2:       return 32'($urandom_range(DEPTH, 1023)) << 2;
      3:       return $urandom;
      default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
  endfunction

  // Monitor: compares on the due cycle and flags any Ready nobody asked for.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("ready_on_time", bus_a.Ready, 1);
        check("addr_error", bus_a.AddrError, e.err);
        check("dataout", bus_a.Dataout, e.dout);
        check("busy_in_resp", bus_a.Busy, 1);
`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
        check("access_count", cnt_a, acc_m);
        acc_m = acc_m + 16'd1;
`endif
      end else if (bus_a.Ready) begin
        check("unexpected_ready", bus_a.Ready, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    bus_a.Req = 1'b0; bus_a.Wr = 1'b0; bus_a.Address = '0; bus_a.Datain = '0;
    bus_b.Req = 1'b0; bus_b.Wr = 1'b1; bus_b.Address = '0; bus_b.Datain = 32'hA5A5_0001;

    // Reset values.
    #12;
    check("rst_ready", bus_a.Ready, 0);
    check("rst_busy", bus_a.Busy, 0);
    check("rst_addr_error", bus_a.AddrError, 0);
    check("rst_dataout", bus_a.Dataout, 0);
    @(negedge clk);
    rst = 1'b0;
    next_free = cyc + 1;

    // Give every word a known value (the write to 252 is dropped).
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i) << 2, $urandom);

    issue(1'b1, 32'd8, 32'hDEADBEEF);
    issue(1'b0, 32'd8, 32'h0);
    issue(1'b0, 32'd252, 32'h0);
    issue(1'b1, 32'd252, 32'h12345678);
    issue(1'b0, 32'd252, 32'h0);
    issue(1'b0, 32'd6, 32'h0);
    issue(1'b1, 32'd256, 32'hCAFEF00D);
    issue(1'b0, 32'd256, 32'h0);
    drain();

    // Reset during WAIT aborts the write.
    wait_idle();
    bus_a.Req = 1'b1; bus_a.Wr = 1'b1; bus_a.Address = 32'd4; bus_a.Datain = 32'h11111111;
    @(negedge clk);
    bus_a.Req = 1'b0;
    check("busy_in_wait", bus_a.Busy, 1);
    rst = 1'b1;
    #1;
    check("abort_ready", bus_a.Ready, 0);
    check("abort_busy", bus_a.Busy, 0);
    check("abort_addr_error", bus_a.AddrError, 0);
    check("abort_dataout", bus_a.Dataout, 0);
    dout_m = 32'h0;
    acc_m  = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    next_free = cyc + 1;
    issue(1'b0, 32'd4, 32'h0);

    // Randomized traffic with idle gaps and bus noise while busy.
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    // LATENCY=1 responder with Req held high for 10 edges: Ready every second cycle.
    @(negedge clk);
    bus_b.Req = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("b2b_ready_pattern", bus_b.Ready, 32'(i % 2));
      if (bus_b.Ready) begin
        pulses++;
        check("b2b_addr_error", bus_b.AddrError, 0);
      end
    end
    bus_b.Req = 1'b0;
    check("b2b_pulse_count", pulses, 5);

`ifdef MEM_BUS_RESPONDER_ACCESS_COUNT_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    acc_m  = 16'h0;
    dout_m = 32'h0;
    next_free = cyc + 1;
    issue(1'b0, 32'd12, 32'h0);
    issue(1'b1, 32'd6, 32'h0);
    issue(1'b0, 32'd252, 32'h0);
    drain();
    repeat (2) @(negedge clk);
    check("count_three", cnt_a, 3);
    dut_a.acc_cnt_q = 16'hFFFF;
    acc_m = 16'hFFFF;
    issue(1'b0, 32'd16, 32'h0);
    drain();
    repeat (2) @(negedge clk);
    check("count_wrap", cnt_a, 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
